// File: rtl/btb_ctrl.sv
// Branch target buffer controller: arbitrates the single RW port of btb_sram
// between fetch lookups and a one-entry buffered commit update with forwarding.
module btb_ctrl #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  output logic        lookup_ready,
  input  logic [31:0] lookup_pc,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [31:0] resp_target,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic        sram_csb0,
  output logic        sram_web0,
  output logic [3:0]  sram_addr0,
  output logic [55:0] sram_din0,
  input  logic [55:0] sram_dout0
);

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE,
    OP_INVAL
  } op_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [15:0] valid;

  logic        buf_valid;
  logic [3:0]  buf_idx;
  logic [25:0] buf_tag;
  logic [29:0] buf_tgt;
  logic        buf_taken;
  logic [3:0]  cnt;

  logic        resp_pending;
  logic [25:0] snap_tag;
  logic        snap_valid;
  logic        snap_fwd;
  logic        snap_fwd_hit;
  logic [29:0] snap_fwd_tgt;

  logic [3:0]  lookup_idx;
  logic [25:0] lookup_tag;
  logic        lookup_fire;
  logic        fwd;
  logic        drain;
  op_e         op;
  logic        sel_hit;
  logic [29:0] sel_tgt;
  logic        unused_bits;

  assign lookup_idx  = lookup_pc[5:2];
  assign lookup_tag  = lookup_pc[31:6];
  assign lookup_fire = lookup_valid && lookup_ready;
  assign fwd         = buf_valid && (buf_idx == lookup_idx);
  assign upd_ready   = !rst && !buf_valid;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Arbitration: a starved buffer pre-empts lookups; otherwise lookups win
  // and the buffer drains only on idle cycles.
  always_comb begin
    op           = OP_IDLE;
    drain        = 1'b0;
    lookup_ready = 1'b0;
    if (!rst) begin
      if (buf_valid && cnt == LIMIT) begin
        drain = 1'b1;
      end else begin
        lookup_ready = 1'b1;
        if (lookup_valid) begin
          op = OP_READ;
        end else if (buf_valid) begin
          drain = 1'b1;
        end
      end
      if (drain) begin
        op = buf_taken ? OP_WRITE : OP_INVAL;
      end
    end
  end

  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    unique case (op)
      OP_READ: begin
        sram_csb0  = 1'b0;
        sram_addr0 = lookup_idx;
      end
      OP_WRITE: begin
        sram_csb0  = 1'b0;
        sram_web0  = 1'b0;
        sram_addr0 = buf_idx;
        sram_din0  = {buf_tag, buf_tgt};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid        <= '0;
      buf_valid    <= 1'b0;
      buf_idx      <= '0;
      buf_tag      <= '0;
      buf_tgt      <= '0;
      buf_taken    <= 1'b0;
      cnt          <= '0;
      resp_pending <= 1'b0;
      snap_tag     <= '0;
      snap_valid   <= 1'b0;
      snap_fwd     <= 1'b0;
      snap_fwd_hit <= 1'b0;
      snap_fwd_tgt <= '0;
    end else begin
      resp_pending <= lookup_fire;
      if (lookup_fire) begin
        snap_tag     <= lookup_tag;
        snap_valid   <= valid[lookup_idx];
        snap_fwd     <= fwd;
        snap_fwd_hit <= buf_taken && (buf_tag == lookup_tag);
        snap_fwd_tgt <= buf_tgt;
      end

      if (op == OP_WRITE) valid[buf_idx] <= 1'b1;
      if (op == OP_INVAL) valid[buf_idx] <= 1'b0;

      if (drain) begin
        buf_valid <= 1'b0;
        cnt       <= '0;
      end else if (buf_valid && cnt != LIMIT) begin
        cnt <= cnt + 4'd1;
      end

      // upd_ready excludes any cycle in which the buffer drains.
      if (upd_valid && upd_ready) begin
        buf_valid <= 1'b1;
        buf_idx   <= upd_pc[5:2];
        buf_tag   <= upd_pc[31:6];
        buf_tgt   <= upd_target[31:2];
        buf_taken <= upd_taken;
      end
    end
  end

  always_comb begin
    if (snap_fwd) begin
      sel_hit = snap_fwd_hit;
      sel_tgt = snap_fwd_tgt;
    end else begin
      sel_hit = snap_valid && (sram_dout0[55:30] == snap_tag);
      sel_tgt = sram_dout0[29:0];
    end
  end

  assign resp_valid  = resp_pending && !rst;
  assign resp_hit    = resp_valid && sel_hit;
  assign resp_target = resp_hit ? {sel_tgt, 2'b00} : '0;

endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl: directed vector table, reset corner case,
// and randomized traffic against an architectural BTB model.
module tb_btb_ctrl;

  localparam int unsigned LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic        lookup_ready;
  logic [31:0] lookup_pc;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_target;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_addr0;
  logic [55:0] sram_din0;
  logic [55:0] sram_dout0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btb_ctrl #(.STARVE_LIMIT(LIM)) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_ready (lookup_ready),
    .lookup_pc    (lookup_pc),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_target  (resp_target),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .sram_csb0    (sram_csb0),
    .sram_web0    (sram_web0),
    .sram_addr0   (sram_addr0),
    .sram_din0    (sram_din0),
    .sram_dout0   (sram_dout0)
  );

  // 16x56 SRAM, registered address, read data the cycle after the request
  logic [55:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    sram_dout0 = '0;
  end
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic [31:0] utgt, input logic utk);
    lookup_valid = lv;
    lookup_pc    = lpc;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_target   = utgt;
    upd_taken    = utk;
  endtask

  typedef struct {
    logic        lv;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        utk;
    logic        lr;
    logic        ur;
    logic        csb;
    logic        web;
    logic [3:0]  addr;
    logic [55:0] din;
    logic        rv;
    logic        rh;
    logic [31:0] rt;
  } vec_t;

  function automatic vec_t mk(input logic lv, input logic [31:0] lpc, input logic uv,
                              input logic [31:0] upc, input logic [31:0] utgt, input logic utk,
                              input logic lr, input logic ur, input logic csb, input logic web,
                              input logic [3:0] addr, input logic [55:0] din,
                              input logic rv, input logic rh, input logic [31:0] rt);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.utgt = utgt; v.utk = utk;
    v.lr = lr; v.ur = ur; v.csb = csb; v.web = web; v.addr = addr; v.din = din;
    v.rv = rv; v.rh = rh; v.rt = rt;
    return v;
  endfunction

  // Architectural model: a 16-entry table where an update accepted in cycle T
  // is visible to lookups accepted from T+1 on.
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [29:0] m_tgt   [16];
  logic        m_buf;
  int          m_wait;
  logic [31:0] mb_pc, mb_tgt;
  logic        mb_tk;
  logic        e_pend, e_hit;
  logic [31:0] e_tgt;

  vec_t vt [20];

  initial begin
    logic [55:0] d1, d2;
    d1 = {26'h40, 30'h800};
    d2 = {26'h40, 30'hC00};

    vt[0]  = mk(1, 32'h1004, 0, 0, 0, 0,                 1, 1, 0, 1, 1, 0,  0, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0,                        1, 1, 1, 1, 0, 0,  1, 0, 0);
    vt[2]  = mk(0, 0, 1, 32'h1004, 32'h2000, 1,          1, 1, 1, 1, 0, 0,  0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0,                        1, 0, 0, 0, 1, d1, 0, 0, 0);
    vt[4]  = mk(1, 32'h1004, 0, 0, 0, 0,                 1, 1, 0, 1, 1, 0,  0, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 0,                        1, 1, 1, 1, 0, 0,  1, 1, 32'h2000);
    vt[6]  = mk(1, 32'h2004, 0, 0, 0, 0,                 1, 1, 0, 1, 1, 0,  0, 0, 0);
    vt[7]  = mk(0, 0, 1, 32'h2004, 0, 0,                 1, 1, 1, 1, 0, 0,  1, 0, 0);
    vt[8]  = mk(0, 0, 0, 0, 0, 0,                        1, 0, 1, 1, 0, 0,  0, 0, 0);
    vt[9]  = mk(1, 32'h1004, 0, 0, 0, 0,                 1, 1, 0, 1, 1, 0,  0, 0, 0);
    vt[10] = mk(0, 0, 0, 0, 0, 0,                        1, 1, 1, 1, 0, 0,  1, 0, 0);
    vt[11] = mk(1, 32'h1004, 1, 32'h1004, 32'h3000, 1,   1, 1, 0, 1, 1, 0,  0, 0, 0);
    vt[12] = mk(1, 32'h1004, 0, 0, 0, 0,                 1, 0, 0, 1, 1, 0,  1, 0, 0);
    vt[13] = mk(1, 32'h1004, 0, 0, 0, 0,                 1, 0, 0, 1, 1, 0,  1, 1, 32'h3000);
    vt[14] = mk(1, 32'h1004, 0, 0, 0, 0,                 1, 0, 0, 1, 1, 0,  1, 1, 32'h3000);
    vt[15] = mk(1, 32'h1004, 0, 0, 0, 0,                 1, 0, 0, 1, 1, 0,  1, 1, 32'h3000);
    vt[16] = mk(1, 32'h1004, 0, 0, 0, 0,                 0, 0, 0, 0, 1, d2, 1, 1, 32'h3000);
    vt[17] = mk(1, 32'h1004, 0, 0, 0, 0,                 1, 1, 0, 1, 1, 0,  0, 0, 0);
    vt[18] = mk(1, 32'h1004, 0, 0, 0, 0,                 1, 1, 0, 1, 1, 0,  1, 1, 32'h3000);
    vt[19] = mk(0, 0, 0, 0, 0, 0,                        1, 1, 1, 1, 0, 0,  1, 1, 32'h3000);

    // Reset with both request inputs asserted: everything must stay quiet
    rst = 1'b1;
    drive(1, 32'h1004, 1, 32'h1004, 32'h2000, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lookup_ready", 64'(lookup_ready), 0);
    chk("rst_upd_ready",    64'(upd_ready),    0);
    chk("rst_resp_valid",   64'(resp_valid),   0);
    chk("rst_resp_hit",     64'(resp_hit),     0);
    chk("rst_resp_target",  64'(resp_target),  0);
    chk("rst_csb0",         64'(sram_csb0),    1);
    chk("rst_web0",         64'(sram_web0),    1);
    chk("rst_addr0",        64'(sram_addr0),   0);
    chk("rst_din0",         64'(sram_din0),    0);

    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      drive(vt[i].lv, vt[i].lpc, vt[i].uv, vt[i].upc, vt[i].utgt, vt[i].utk);
      @(negedge clk);
      chk($sformatf("v%0d_lookup_ready", i), 64'(lookup_ready), 64'(vt[i].lr));
      chk($sformatf("v%0d_upd_ready", i),    64'(upd_ready),    64'(vt[i].ur));
      chk($sformatf("v%0d_csb0", i),         64'(sram_csb0),    64'(vt[i].csb));
      chk($sformatf("v%0d_resp_valid", i),   64'(resp_valid),   64'(vt[i].rv));
      if (!vt[i].csb) begin
        chk($sformatf("v%0d_web0", i),  64'(sram_web0),  64'(vt[i].web));
        chk($sformatf("v%0d_addr0", i), 64'(sram_addr0), 64'(vt[i].addr));
        if (!vt[i].web) chk($sformatf("v%0d_din0", i), 64'(sram_din0), 64'(vt[i].din));
      end
      if (vt[i].rv) begin
        chk($sformatf("v%0d_resp_hit", i),    64'(resp_hit),    64'(vt[i].rh));
        chk($sformatf("v%0d_resp_target", i), 64'(resp_target), 64'(vt[i].rt));
      end
    end

    // Reset while an update is buffered and a response is pending
    @(posedge clk); #1;
    drive(1, 32'h1004, 1, 32'h5010, 32'h7000, 1);
    @(negedge clk);
    chk("rm_accept_upd_ready", 64'(upd_ready), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rm_in_rst_csb0",       64'(sram_csb0),  1);
    chk("rm_in_rst_resp_valid", 64'(resp_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rm_after_csb0",      64'(sram_csb0), 1);
    chk("rm_after_upd_ready", 64'(upd_ready), 1);
    @(posedge clk); #1;
    drive(1, 32'h5010, 0, 0, 0, 0);
    @(negedge clk);
    chk("rm_lookup_csb0", 64'(sram_csb0), 0);
    @(posedge clk); #1;
    drive(1, 32'h1004, 0, 0, 0, 0);
    @(negedge clk);
    chk("rm_buffered_pc_valid", 64'(resp_valid), 1);
    chk("rm_buffered_pc_hit",   64'(resp_hit),   0);
    chk("rm_buffered_pc_tgt",   64'(resp_target), 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rm_old_entry_valid", 64'(resp_valid), 1);
    chk("rm_old_entry_hit",   64'(resp_hit),   0);

    // Randomized traffic from a clean (all-invalid, empty buffer) state
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
    end
    m_buf  = 1'b0;
    m_wait = 0;
    mb_pc = '0; mb_tgt = '0; mb_tk = 1'b0;
    e_pend = 1'b0; e_hit = 1'b0; e_tgt = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        lv, uv, utk, exp_lr, exp_ur, dr;
      logic [31:0] lpc, upc, utgt;
      logic [25:0] tags [3];
      logic [3:0]  li;
      tags[0] = 26'h40;
      tags[1] = 26'h80;
      tags[2] = 26'($urandom);
      lv   = ($urandom % 10) < 7;
      uv   = ($urandom % 10) < 4;
      utk  = ($urandom % 4) != 0;
      lpc  = {tags[$urandom_range(0, 2)], 4'($urandom), 2'($urandom)};
      upc  = {tags[$urandom_range(0, 2)], 4'($urandom), 2'($urandom)};
      utgt = $urandom;

      @(posedge clk); #1;
      drive(lv, lpc, uv, upc, utgt, utk);
      @(negedge clk);

      exp_lr = !(m_buf && m_wait == int'(LIM));
      exp_ur = !m_buf;
      dr     = m_buf && (!exp_lr || !lv);
      chk("rnd_lookup_ready", 64'(lookup_ready), 64'(exp_lr));
      chk("rnd_upd_ready",    64'(upd_ready),    64'(exp_ur));
      chk("rnd_resp_valid",   64'(resp_valid),   64'(e_pend));
      if (e_pend) begin
        chk("rnd_resp_hit",    64'(resp_hit),    64'(e_hit));
        chk("rnd_resp_target", 64'(resp_target), 64'(e_tgt));
      end
      if (exp_lr && lv) begin
        chk("rnd_read_csb0",  64'(sram_csb0),  0);
        chk("rnd_read_web0",  64'(sram_web0),  1);
        chk("rnd_read_addr0", 64'(sram_addr0), 64'(lpc[5:2]));
      end else if (dr && mb_tk) begin
        chk("rnd_wr_csb0",  64'(sram_csb0),  0);
        chk("rnd_wr_web0",  64'(sram_web0),  0);
        chk("rnd_wr_addr0", 64'(sram_addr0), 64'(mb_pc[5:2]));
        chk("rnd_wr_din0",  64'(sram_din0),  64'({mb_pc[31:6], mb_tgt[31:2]}));
      end else begin
        chk("rnd_idle_csb0", 64'(sram_csb0), 1);
      end

      e_pend = exp_lr && lv;
      li     = lpc[5:2];
      e_hit  = m_valid[li] && (m_tag[li] == lpc[31:6]);
      e_tgt  = e_hit ? {m_tgt[li], 2'b00} : 32'h0;

      if (dr) begin
        m_buf = 1'b0;
      end else if (m_buf && m_wait < int'(LIM)) begin
        m_wait++;
      end
      if (exp_ur && uv) begin
        m_buf  = 1'b1;
        m_wait = 0;
        mb_pc  = upc;
        mb_tgt = utgt;
        mb_tk  = utk;
        m_valid[upc[5:2]] = utk;
        if (utk) begin
          m_tag[upc[5:2]] = upc[31:6];
          m_tgt[upc[5:2]] = utgt[31:2];
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
